seq_timing_gen: RTL and testbench

SEQ_TIMING_GEN -- requirements
Module: seq_timing_gen

---
 rtl/seq_timing_gen_if.sv | 32 +++
 rtl/seq_timing_gen.sv | 114 +++++++++++
 tb/tb_seq_timing_gen.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_timing_gen_if.sv
// Control-unit timing bus between the sequence requester and seq_timing_gen.
// The pause signal exists only when SEQ_PAUSE_EN is defined.
interface seq_timing_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] n_iter;
`ifdef SEQ_PAUSE_EN
  logic             pause;
`endif
  logic [1:0]       T;
  logic             E;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, n_iter,
`ifdef SEQ_PAUSE_EN
    output pause,
`endif
    input  T, E, busy, done, iter_cnt
  );

  modport slave (
    input  start, n_iter,
`ifdef SEQ_PAUSE_EN
    input  pause,
`endif
    output T, E, busy, done, iter_cnt
  );
endinterface

// File: rtl/seq_timing_gen.sv
// Four-step timing generator (T0..T3) repeated n_iter times, then a one-cycle FIN.
// Optional SEQ_PAUSE_EN macro adds a pause input that freezes the RUN state.
module seq_timing_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_timing_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       t_q, t_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] nlat_q, nlat_d;
  logic [CNT_W-1:0] iter_inc;
  logic             hold;

`ifdef SEQ_PAUSE_EN
  always_comb hold = bus.pause;
`else
  always_comb hold = 1'b0;
`endif

  always_comb iter_inc = iter_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    e_d     = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    iter_d  = iter_q;
    nlat_d  = nlat_q;
    case (state_q)
      IDLE: begin
        t_d    = 2'b00;
        busy_d = 1'b0;
        if (bus.start) begin
          iter_d = '0;
          busy_d = 1'b1;
          if (bus.n_iter != '0) begin
            nlat_d  = bus.n_iter;
            state_d = RUN;
          end else begin
            state_d = FIN;
            e_d     = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          t_d = t_q + 2'b01;
          if (t_q == 2'b11) begin
            iter_d = iter_inc;
            // Compare the incremented count so n_iter = 2^CNT_W-1 ends before wrapping.
            if (iter_inc == nlat_q) begin
              state_d = FIN;
              t_d     = 2'b00;
              e_d     = 1'b1;
              done_d  = 1'b1;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        t_d     = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        t_d     = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= 2'b00;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
      nlat_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iter_q  <= iter_d;
      nlat_q  <= nlat_d;
    end
  end

  assign bus.T        = t_q;
  assign bus.E        = e_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter_cnt = iter_q;

endmodule

// File: tb/tb_seq_timing_gen.sv
// Directed self-checking bench for seq_timing_gen; "cycle c" means 1 time unit after rising edge c.
// Pause scenario is compiled only when SEQ_PAUSE_EN is defined.
module tb_seq_timing_gen;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_timing_gen_if #(.CNT_W(8)) bus ();

  seq_timing_gen #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.n_iter = 8'd0;
    tick();
    tick();
    n_cmp++;
    if (bus.T !== 2'b00 || bus.E !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.iter_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset: T=%b E=%b busy=%b done=%b iter=%0d, required T=00 E=0 busy=0 done=0 iter=0",
               bus.T, bus.E, bus.busy, bus.done, bus.iter_cnt);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.T !== 2'b00 || bus.iter_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b T=%b iter=%0d, required busy=0 T=00 iter=0", bus.busy, bus.T, bus.iter_cnt);
    end
  endtask

  task automatic test_single();
    bus.start = 1'b1;
    bus.n_iter = 8'd1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (bus.T !== 2'(c - 1) || bus.busy !== 1'b1 || bus.E !== 1'b0 || bus.done !== 1'b0 || bus.iter_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL single_run c%0d: T=%b busy=%b E=%b done=%b iter=%0d, required T=%b busy=1 E=0 done=0 iter=0",
                 c, bus.T, bus.busy, bus.E, bus.done, bus.iter_cnt, 2'(c - 1));
      end
      tick();
    end
    n_cmp++;
    if (bus.T !== 2'b00 || bus.E !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.iter_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL single_fin: T=%b E=%b done=%b busy=%b iter=%0d, required T=00 E=1 done=1 busy=1 iter=1",
               bus.T, bus.E, bus.done, bus.busy, bus.iter_cnt);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.E !== 1'b0 || bus.done !== 1'b0 || bus.iter_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL single_idle: busy=%b E=%b done=%b iter=%0d, required busy=0 E=0 done=0 iter=1",
               bus.busy, bus.E, bus.done, bus.iter_cnt);
    end
  endtask

  task automatic test_multi();
    int dones = 0;
    int bad = 0;
    bus.start = 1'b1;
    bus.n_iter = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.done === 1'b1) dones++;
      if (c <= 12) begin
        if (bus.T !== 2'((c - 1) % 4) || bus.iter_cnt !== 8'((c - 1) / 4) || bus.busy !== 1'b1) bad++;
      end else if (c == 13) begin
        if (bus.done !== 1'b1 || bus.E !== 1'b1 || bus.iter_cnt !== 8'd3) bad++;
      end else begin
        if (bus.busy !== 1'b0 || bus.iter_cnt !== 8'd3) bad++;
      end
      if (c < 14) tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL multi_seq: %0d bad cycles, required 0", bad);
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL multi_done_count: %0d pulses, required 1", dones);
    end
  endtask

  task automatic test_zero();
    bus.start = 1'b1;
    bus.n_iter = 8'd0;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.T !== 2'b00 || bus.E !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.iter_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL zero_fin: T=%b E=%b done=%b busy=%b iter=%0d, required T=00 E=1 done=1 busy=1 iter=0",
               bus.T, bus.E, bus.done, bus.busy, bus.iter_cnt);
    end
    tick();
    n_cmp++;
    if (bus.T !== 2'b00 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.iter_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL zero_idle: T=%b done=%b busy=%b iter=%0d, required T=00 done=0 busy=0 iter=0",
               bus.T, bus.done, bus.busy, bus.iter_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    bus.start = 1'b1;
    bus.n_iter = 8'd2;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.T !== 2'((c - 1) % 4) || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      if (c == 3) begin
        bus.start = 1'b1;
        bus.n_iter = 8'd5;
      end
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ignore_seq: %0d bad cycles, required 0", bad);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.E !== 1'b1 || bus.iter_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL ignore_fin: done=%b E=%b iter=%0d, required done=1 E=1 iter=2", bus.done, bus.E, bus.iter_cnt);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.iter_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b iter=%0d, required busy=0 iter=2", bus.busy, bus.iter_cnt);
    end
    tick();
    bus.start = 1'b0;
    bad = 0;
    for (int c = 11; c <= 30; c++) begin
      if (bus.T !== 2'((c - 11) % 4) || bus.iter_cnt !== 8'((c - 11) / 4) || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_seq: %0d bad cycles, required 0", bad);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.iter_cnt !== 8'd5) begin
      n_err++;
      $display("FAIL b2b_fin: done=%b iter=%0d, required done=1 iter=5", bus.done, bus.iter_cnt);
    end
    tick();
  endtask

  task automatic test_abort();
    int dones = 0;
    bus.start = 1'b1;
    bus.n_iter = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    n_cmp++;
    if (bus.T !== 2'b01 || bus.iter_cnt !== 8'd1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre: T=%b iter=%0d busy=%b, required T=01 iter=1 busy=1", bus.T, bus.iter_cnt, bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.T !== 2'b00 || bus.iter_cnt !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.E !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: T=%b iter=%0d busy=%b done=%b E=%b, required all zero",
               bus.T, bus.iter_cnt, bus.busy, bus.done, bus.E);
    end
    for (int c = 0; c < 20; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_no_done: %0d active cycles, required 0", dones);
    end
  endtask

  task automatic test_rst_priority();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.n_iter = 8'd2;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.T !== 2'b00 || bus.iter_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL rst_priority: busy=%b T=%b iter=%0d, required busy=0 T=00 iter=0", bus.busy, bus.T, bus.iter_cnt);
    end
  endtask

  task automatic test_max();
    int dones = 0;
    int bad = 0;
    bus.start = 1'b1;
    bus.n_iter = 8'd255;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 1020; c++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.T !== 2'((c - 1) % 4) || bus.iter_cnt !== 8'((c - 1) / 4) || bus.busy !== 1'b1) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0 || dones != 0) begin
      n_err++;
      $display("FAIL max_seq: %0d bad cycles %0d early done, required 0 and 0", bad, dones);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.E !== 1'b1 || bus.iter_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL max_fin: done=%b E=%b iter=%0d, required done=1 E=1 iter=255", bus.done, bus.E, bus.iter_cnt);
    end
    tick();
  endtask

`ifdef SEQ_PAUSE_EN
  task automatic test_pause();
    int bad = 0;
    bus.start = 1'b1;
    bus.n_iter = 8'd2;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.pause = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      if (bus.T !== 2'b10 || bus.iter_cnt !== 8'd0 || bus.busy !== 1'b1) bad++;
      if (c == 6) bus.pause = 1'b0;
      tick();
    end
    for (int c = 7; c <= 11; c++) begin
      if (bus.T !== 2'((c - 4) % 4) || bus.done !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL pause_seq: %0d bad cycles, required 0", bad);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.iter_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL pause_fin: done=%b iter=%0d, required done=1 iter=2", bus.done, bus.iter_cnt);
    end
    bus.pause = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL pause_in_fin: busy=%b done=%b, required busy=0 done=0", bus.busy, bus.done);
    end
    bus.pause = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.n_iter = 8'd0;
`ifdef SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_back_to_back();
    test_abort();
    test_rst_priority();
    test_max();
`ifdef SEQ_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
